// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage: ALU opcodes, branch kinds,
// operand-A selects, branch funct3 codes and the EX/MEM register layout.
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BR   = 2'd1,
        BR_JAL  = 2'd2,
        BR_JALR = 2'd3
    } br_type_e;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2,
        OPA_RSVD = 2'd3
    } opa_sel_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic [2:0]  funct3;
    } ex_mem_t;

endpackage

// File: rtl/barrel_shifter.sv
// 32-bit barrel shifter: dir=0 shifts left, dir=1 shifts right, arith selects
// sign fill on right shifts.
module barrel_shifter (
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    input  logic        dir,
    input  logic        arith,
    output logic [31:0] data_out
);

    logic        fill;
    logic [63:0] right_ext;

    always_comb begin
        fill      = arith & data_in[31];
        right_ext = {{32{fill}}, data_in} >> shamt;
        if (dir) begin
            data_out = right_ext[31:0];
        end else begin
            data_out = data_in << shamt;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the non-forwarding 5-stage pipeline: operand select, ALU,
// shifter, branch/jump resolution with PC redirect, and the EX/MEM register.
module ex_stage
    import ex_pkg::*;
#(
    parameter int          XLEN           = 32,
    parameter logic [31:0] RESET_PC_PLUS4 = 32'h0000_0004
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_op,
    input  logic [1:0]      id_opa_sel,
    input  logic            id_opb_sel,
    input  logic [1:0]      id_br_type,
    input  logic [2:0]      id_funct3,
    input  logic [4:0]      id_rd,
    input  logic            id_reg_we,
    input  logic            id_mem_re,
    input  logic            id_mem_we,
    input  logic            stall,
    input  logic            flush,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_alu_result,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc_plus4,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_we,
    output logic            ex_mem_re,
    output logic            ex_mem_we,
    output logic [2:0]      ex_funct3
);

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] shift_out;
    logic [31:0] alu_res;
    logic [31:0] pc_plus4;
    logic [31:0] pc_imm;
    logic [31:0] rs1_imm;
    logic        shift_dir;
    logic        shift_arith;
    logic        cond;
    logic        taken;
    alu_op_e     alu_op;
    br_type_e    br_type;
    ex_mem_t     ex_mem_d;
    ex_mem_t     ex_mem_q;

    assign alu_op  = alu_op_e'(id_alu_op);
    assign br_type = br_type_e'(id_br_type);

    always_comb begin
        case (opa_sel_e'(id_opa_sel))
            OPA_RS1: op_a = id_rs1_data;
            OPA_PC:  op_a = id_pc;
            default: op_a = 32'h0;
        endcase
        op_b = id_opb_sel ? id_imm : id_rs2_data;
    end

    always_comb begin
        shift_dir   = (alu_op == ALU_SRL) || (alu_op == ALU_SRA);
        shift_arith = (alu_op == ALU_SRA);
    end

    barrel_shifter u_shifter (
        .data_in  (op_a),
        .shamt    (op_b[4:0]),
        .dir      (shift_dir),
        .arith    (shift_arith),
        .data_out (shift_out)
    );

    always_comb begin
        pc_plus4 = id_pc + 32'd4;
        case (alu_op)
            ALU_ADD:   alu_res = op_a + op_b;
            ALU_SUB:   alu_res = op_a - op_b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:   alu_res = shift_out;
            ALU_SLT:   alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  alu_res = {31'b0, op_a < op_b};
            ALU_XOR:   alu_res = op_a ^ op_b;
            ALU_OR:    alu_res = op_a | op_b;
            ALU_AND:   alu_res = op_a & op_b;
            ALU_PASSB: alu_res = op_b;
            default:   alu_res = 32'h0;
        endcase
        // Jumps write the link address regardless of the ALU opcode.
        if (br_type == BR_JAL || br_type == BR_JALR) begin
            alu_res = pc_plus4;
        end
    end

    always_comb begin
        case (id_funct3)
            F3_BEQ:  cond = (id_rs1_data == id_rs2_data);
            F3_BNE:  cond = (id_rs1_data != id_rs2_data);
            F3_BLT:  cond = $signed(id_rs1_data) < $signed(id_rs2_data);
            F3_BGE:  cond = $signed(id_rs1_data) >= $signed(id_rs2_data);
            F3_BLTU: cond = id_rs1_data < id_rs2_data;
            F3_BGEU: cond = id_rs1_data >= id_rs2_data;
            default: cond = 1'b0;
        endcase
        taken = ((br_type == BR_BR) && cond) || (br_type == BR_JAL) || (br_type == BR_JALR);
    end

    always_comb begin
        pc_imm   = id_pc + id_imm;
        rs1_imm  = id_rs1_data + id_imm;
        redirect = ~rst & id_valid & taken & ~stall & ~flush;
        if (rst) begin
            redirect_pc = 32'h0;
        end else if (br_type == BR_JALR) begin
            redirect_pc = {rs1_imm[31:1], 1'b0};
        end else begin
            redirect_pc = pc_imm;
        end
    end

    // Flush only clears the control bits; data fields keep their last values.
    always_comb begin
        ex_mem_d = ex_mem_q;
        if (flush) begin
            ex_mem_d.valid  = 1'b0;
            ex_mem_d.reg_we = 1'b0;
            ex_mem_d.mem_re = 1'b0;
            ex_mem_d.mem_we = 1'b0;
        end else if (!stall) begin
            ex_mem_d.valid      = id_valid;
            ex_mem_d.alu_result = alu_res;
            ex_mem_d.store_data = id_rs2_data;
            ex_mem_d.pc_plus4   = pc_plus4;
            ex_mem_d.rd         = id_rd;
            ex_mem_d.reg_we     = id_valid & id_reg_we;
            ex_mem_d.mem_re     = id_valid & id_mem_re;
            ex_mem_d.mem_we     = id_valid & id_mem_we;
            ex_mem_d.funct3     = id_funct3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_q          <= '0;
            ex_mem_q.pc_plus4 <= RESET_PC_PLUS4;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign ex_valid      = ex_mem_q.valid;
    assign ex_alu_result = ex_mem_q.alu_result;
    assign ex_store_data = ex_mem_q.store_data;
    assign ex_pc_plus4   = ex_mem_q.pc_plus4;
    assign ex_rd         = ex_mem_q.rd;
    assign ex_reg_we     = ex_mem_q.reg_we;
    assign ex_mem_re     = ex_mem_q.mem_re;
    assign ex_mem_we     = ex_mem_q.mem_we;
    assign ex_funct3     = ex_mem_q.funct3;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the non-forwarding 5-stage pipeline; consumes ID/EX register outputs.
- Selects ALU operands, computes the ALU result, and drives the 32-bit barrel shifter for SLL/SRL/SRA.
- Resolves branches and jumps and issues a PC redirect.
- Captures results into the EX/MEM pipeline register, with stall hold and bubble insertion.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC_PLUS4, 32'h0000_0004, value ex_pc_plus4 takes on reset.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  ID/EX slot holds a real instruction.
- id_pc  in  32  instruction PC.
- id_rs1_data  in  32  register-file read 1; no forwarding.
- id_rs2_data  in  32  register-file read 2.
- id_imm  in  32  sign-extended immediate.
- id_alu_op  in  4  alu_op_e code.
- id_opa_sel  in  2  operand A: 0 = rs1, 1 = pc, 2 = zero.
- id_opb_sel  in  1  operand B: 0 = rs2, 1 = imm.
- id_br_type  in  2  0 = none, 1 = branch, 2 = jal, 3 = jalr.
- id_funct3  in  3  branch condition / memory size.
- id_rd  in  5  destination register.
- id_reg_we  in  1  write-back enable.
- id_mem_re  in  1  load.
- id_mem_we  in  1  store.
- stall  in  1  hold EX/MEM (from the MEM stage or hazard unit).
- flush  in  1  load a bubble into EX/MEM.
- redirect  out  1  combinational; taken branch or jump.
- redirect_pc  out  32  combinational target.
- ex_valid, ex_alu_result[32], ex_store_data[32], ex_pc_plus4[32], ex_rd[5], ex_reg_we, ex_mem_re, ex_mem_we, ex_funct3[3]  out  registered EX/MEM fields.

Behaviour:
- Reset (async, rst=1): all ex_* outputs are 0, except ex_pc_plus4 = RESET_PC_PLUS4. redirect and redirect_pc are 0 while rst is high.
- Operands:
  - A = rs1, pc, or 0 per id_opa_sel; id_opa_sel = 3 is treated as 0.
  - B = rs2 or imm per id_opb_sel.
- ALU result:
  - ADD: A+B, mod 2^32. SUB: A−B.
  - AND, OR, XOR: bitwise.
  - SLT: signed compare, result 1/0. SLTU: unsigned compare, result 1/0.
  - PASSB: B (used for LUI).
  - Any undefined code produces 0.
- Shifts:
  - Barrel-shifter instance with in = A, shamt = B[4:0]; B[31:5] are ignored.
  - SLL: dir=0, arith=0. SRL: dir=1, arith=0. SRA: dir=1, arith=1.
  - shamt = 0 returns A unchanged.
- Branch compare, always on rs1 vs rs2:
  - funct3 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu.
  - 010 and 011 are never taken.
- taken = (br_type==1 & cond) | br_type==2 | br_type==3.
- redirect = id_valid & taken & ~stall & ~flush.
- Redirect target:
  - br_type 1 or 2: redirect_pc = pc + imm.
  - br_type 3: redirect_pc = (rs1 + imm) with bit 0 forced to 0.
  - redirect_pc is don't-care when redirect=0 but must not be X; drive the pc+imm value.
  - No misalignment trap; bit 1 passes through.
- Jumps: for br_type 2 or 3, ex_alu_result = pc + 4.
- EX/MEM register update priority per rising edge:
  1. flush=1: ex_valid, ex_reg_we, ex_mem_re and ex_mem_we go to 0; data fields hold.
  2. else stall=1: all ex_* fields hold.
  3. else: all fields load from the current inputs.
- Flush wins over stall when both are asserted.
- When id_valid = 0, the loaded ex_valid, ex_reg_we, ex_mem_re and ex_mem_we are forced to 0.
- ex_rd = 0 with reg_we = 1 passes through unchanged; x0 masking happens at the register file.
- ex_store_data = rs2 unmodified.
- ex_pc_plus4 = pc + 4, wrapping at 2^32.
- Latency: one cycle from inputs to ex_*; redirect is same-cycle combinational.
- Reset asserted mid-stall clears immediately; the first edge after deassertion loads the inputs normally.

Decomposition:
- Package ex_pkg holds:
  - typedef alu_op_e (4-bit): ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
  - br_type_e: NONE, BR, JAL, JALR.
  - opa_sel_e.
  - funct3 branch constants.
- One sub-module: the existing barrel_shifter, instantiated unchanged.
- The ALU and branch logic stay inline.

Test Plan:
- SRA: A=32'h8000_00F0 (rs1), B=imm 4, id_alu_op=SRA, id_valid=1 → ex_alu_result=32'hF800_000F after one edge. Repeat with SRL → 32'h0800_000F.
- SLL with rs2=32'h0000_0021 (shamt=1) on rs1=32'h4000_0001 → 32'h8000_0002; SLT with rs1=32'hFFFF_FFFF, rs2=1 → 1; SLTU with the same operands → 0.
- BEQ, pc=32'h100, imm=32'h20, rs1=rs2=5 → redirect=1, redirect_pc=32'h120 in the same cycle. With rs2=6 → redirect=0.
- JALR, pc=32'h200, rs1=32'h1001, imm=2 → redirect_pc=32'h1002, ex_alu_result=32'h204, ex_reg_we=1.
- Stall=1 for 3 cycles with changing inputs → ex_* constant, redirect=0. Assert flush with stall → ex_valid=0 next edge. Clear both → the next instruction loads.
- Assert rst asynchronously between edges while ex_valid=1 → ex_valid=0 and ex_pc_plus4=32'h4 immediately. After release, id_valid=0 → ex_reg_we stays 0.
